// File: rtl/obstacle_scheduler.sv
// Obstacle spawn scheduler: counts frames between spawns, picks lane/kind from
// the random word, claims the lowest free slot and hands a valid/ready request
// to the obstacle engine. Also owns level and spawn-gap progression.
module obstacle_scheduler #(
  parameter int unsigned N_SLOTS     = 8,
  parameter int unsigned GAP_INIT    = 60,
  parameter int unsigned GAP_MIN     = 20,
  parameter int unsigned GAP_STEP    = 4,
  parameter int unsigned LEVEL_EVERY = 16,
  localparam int unsigned SLOT_W     = $clog2(N_SLOTS)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              frame_tick,
  input  logic              run,
  input  logic [4:0]        rnd,
  input  logic [N_SLOTS-1:0] slot_free,
  output logic              spawn_valid,
  input  logic              spawn_ready,
  output logic [SLOT_W-1:0] spawn_slot,
  output logic [1:0]        spawn_lane,
  output logic              spawn_kind,
  output logic [7:0]        gap_cur,
  output logic [3:0]        level,
  output logic [15:0]       spawn_count,
  output logic              drop
);

  localparam int unsigned GAP_W   = 8;
  localparam int unsigned LEVEL_W = 4;
  localparam int unsigned COUNT_W = 16;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_PICK, S_ISSUE} state_t;

  state_t               state_q, state_d;
  logic [GAP_W-1:0]     cnt_q, cnt_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic [LEVEL_W-1:0]   level_q, level_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic [SLOT_W-1:0]    slot_q, slot_d;
  logic [1:0]           lane_q, lane_d;
  logic                 kind_q, kind_d;
  logic                 valid_q, valid_d;
  logic                 drop_q, drop_d;

  logic [SLOT_W-1:0]    first_slot;
  logic                 found;
  logic [COUNT_W-1:0]   count_inc;
  logic                 level_up;
  logic [GAP_W-1:0]     gap_dec;
  logic                 unused_rnd;

  // rnd[3] plays no part in lane or kind selection
  assign unused_rnd = rnd[3];

  // Lowest-index free slot
  always_comb begin
    first_slot = '0;
    found      = 1'b0;
    for (int i = 0; i < int'(N_SLOTS); i++) begin
      if (slot_free[i] && !found) begin
        first_slot = SLOT_W'(i);
        found      = 1'b1;
      end
    end
  end

  // Difficulty step taken on an accepted spawn; gap clamps without underflow
  always_comb begin
    count_inc = count_q + 16'd1;
    level_up  = ((32'(count_inc) % LEVEL_EVERY) == 32'd0);
    if (32'(gap_q) < GAP_MIN + GAP_STEP) begin
      gap_dec = GAP_W'(GAP_MIN);
    end else begin
      gap_dec = gap_q - GAP_W'(GAP_STEP);
    end
  end

  // Next-state and next-output logic; run low overrides everything
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    level_d = level_q;
    count_d = count_q;
    slot_d  = slot_q;
    lane_d  = lane_q;
    kind_d  = kind_q;
    drop_d  = 1'b0;
    if (!run) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_WAIT;
          level_d = '0;
          gap_d   = GAP_W'(GAP_INIT);
          count_d = '0;
          cnt_d   = GAP_W'(GAP_INIT);
        end
        S_WAIT: begin
          if (frame_tick) begin
            if (cnt_q <= 8'd1) begin
              state_d = S_PICK;
            end else begin
              cnt_d = cnt_q - 8'd1;
            end
          end
        end
        S_PICK: begin
          if (!found) begin
            drop_d  = 1'b1;
            cnt_d   = gap_q;
            state_d = S_WAIT;
          end else begin
            slot_d  = first_slot;
            lane_d  = rnd[1:0];
            kind_d  = rnd[4] & rnd[2];
            state_d = S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (valid_q && spawn_ready) begin
            count_d = count_inc;
            if (level_up) begin
              if (level_q != 4'd15) begin
                level_d = level_q + 4'd1;
              end
              gap_d = gap_dec;
              cnt_d = gap_dec;
            end else begin
              cnt_d = gap_q;
            end
            state_d = S_WAIT;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
    valid_d = (state_d == S_ISSUE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= GAP_W'(GAP_INIT);
      gap_q   <= GAP_W'(GAP_INIT);
      level_q <= '0;
      count_q <= '0;
      slot_q  <= '0;
      lane_q  <= '0;
      kind_q  <= 1'b0;
      valid_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      level_q <= level_d;
      count_q <= count_d;
      slot_q  <= slot_d;
      lane_q  <= lane_d;
      kind_q  <= kind_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
    end
  end

  assign spawn_valid = valid_q;
  assign spawn_slot  = slot_q;
  assign spawn_lane  = lane_q;
  assign spawn_kind  = kind_q;
  assign gap_cur     = gap_q;
  assign level       = level_q;
  assign spawn_count = count_q;
  assign drop        = drop_q;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// Scoreboard bench for obstacle_scheduler: a game-level reference model
// predicts spawn offers and drops into a queue; a monitor pops and compares.
module tb_obstacle_scheduler;

  localparam int N_SLOTS     = 8;
  localparam int GAP_INIT    = 7;
  localparam int GAP_MIN     = 2;
  localparam int GAP_STEP    = 3;
  localparam int LEVEL_EVERY = 2;
  localparam int SW          = $clog2(N_SLOTS);

  logic               clk = 1'b0;
  logic               rstn = 1'b0;
  logic               frame_tick = 1'b0;
  logic               run = 1'b0;
  logic [4:0]         rnd = '0;
  logic [N_SLOTS-1:0] slot_free = '0;
  logic               spawn_ready = 1'b0;
  logic               spawn_valid;
  logic [SW-1:0]      spawn_slot;
  logic [1:0]         spawn_lane;
  logic               spawn_kind;
  logic [7:0]         gap_cur;
  logic [3:0]         level;
  logic [15:0]        spawn_count;
  logic               drop;

  obstacle_scheduler #(
    .N_SLOTS(N_SLOTS), .GAP_INIT(GAP_INIT), .GAP_MIN(GAP_MIN),
    .GAP_STEP(GAP_STEP), .LEVEL_EVERY(LEVEL_EVERY)
  ) dut (
    .clk(clk), .rstn(rstn), .frame_tick(frame_tick), .run(run), .rnd(rnd),
    .slot_free(slot_free), .spawn_valid(spawn_valid), .spawn_ready(spawn_ready),
    .spawn_slot(spawn_slot), .spawn_lane(spawn_lane), .spawn_kind(spawn_kind),
    .gap_cur(gap_cur), .level(level), .spawn_count(spawn_count), .drop(drop)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Game-level rules: difficulty follows directly from the accepted count
  function automatic int gap_of(input int acc);
    int g;
    g = GAP_INIT - GAP_STEP * (acc / LEVEL_EVERY);
    return (g < GAP_MIN) ? GAP_MIN : g;
  endfunction

  function automatic int level_of(input int acc);
    int l;
    l = acc / LEVEL_EVERY;
    return (l > 15) ? 15 : l;
  endfunction

  function automatic int lowest(input int v);
    for (int i = 0; i < N_SLOTS; i++) if (((v >> i) & 1) == 1) return i;
    return -1;
  endfunction

  typedef struct {
    int cyc;
    bit is_drop;
    int slot;
    int lane;
    int kind;
  } ev_t;

  ev_t evq[$];

  // Model state: 0 stopped, 1 counting frames, 2 choosing, 3 offering
  int cyc = 0;
  int mode = 0;
  int frames_left = 0;
  int accepted = 0;
  bit exp_drop = 1'b0;
  ev_t m_ev;
  int m_s;
  int m_r;

  // Reference model, advanced on each active clock edge
  initial forever begin
    @(posedge clk or negedge rstn);
    if (!rstn) begin
      mode = 0;
      accepted = 0;
      exp_drop = 1'b0;
      evq.delete();
    end else begin
      cyc++;
      exp_drop = 1'b0;
      if (!run) begin
        mode = 0;
      end else begin
        case (mode)
          0: begin
            mode = 1;
            accepted = 0;
            frames_left = GAP_INIT;
          end
          1: if (frame_tick) begin
            frames_left--;
            if (frames_left == 0) mode = 2;
          end
          2: begin
            m_s = lowest(int'(slot_free));
            m_r = int'(rnd);
            m_ev.cyc = cyc;
            if (m_s < 0) begin
              exp_drop = 1'b1;
              m_ev.is_drop = 1'b1;
              m_ev.slot = 0;
              m_ev.lane = 0;
              m_ev.kind = 0;
              frames_left = gap_of(accepted);
              mode = 1;
            end else begin
              m_ev.is_drop = 1'b0;
              m_ev.slot = m_s;
              m_ev.lane = m_r % 4;
              m_ev.kind = ((m_r >> 4) & (m_r >> 2)) & 1;
              mode = 3;
            end
            evq.push_back(m_ev);
          end
          default: if (spawn_ready) begin
            accepted++;
            frames_left = gap_of(accepted);
            mode = 1;
          end
        endcase
      end
    end
  end

  // Monitor: compares registered outputs on the falling edge
  bit  prev_valid = 1'b0;
  ev_t cur;
  ev_t dev;
  initial forever begin
    @(negedge clk);
    if (!rstn) begin
      prev_valid = 1'b0;
      continue;
    end
    chk("valid", int'(spawn_valid), int'(mode == 3));
    chk("drop", int'(drop), int'(exp_drop));
    chk("gap_cur", int'(gap_cur), gap_of(accepted));
    chk("level", int'(level), level_of(accepted));
    chk("spawn_count", int'(spawn_count), accepted % 65536);
    if (spawn_valid && !prev_valid) begin
      if (evq.size() == 0) begin
        chk("offer_unexpected", 1, 0);
      end else begin
        cur = evq.pop_front();
        chk("offer_is_spawn", int'(cur.is_drop), 0);
        chk("offer_cycle", cyc, cur.cyc);
        chk("offer_slot", int'(spawn_slot), cur.slot);
        chk("offer_lane", int'(spawn_lane), cur.lane);
        chk("offer_kind", int'(spawn_kind), cur.kind);
      end
    end else if (spawn_valid) begin
      chk("hold_slot", int'(spawn_slot), cur.slot);
      chk("hold_lane", int'(spawn_lane), cur.lane);
      chk("hold_kind", int'(spawn_kind), cur.kind);
    end
    if (drop) begin
      if (evq.size() == 0) begin
        chk("drop_unexpected", 1, 0);
      end else begin
        dev = evq.pop_front();
        chk("drop_is_drop", int'(dev.is_drop), 1);
        chk("drop_cycle", cyc, dev.cyc);
      end
    end
    prev_valid = spawn_valid;
  end

  task automatic step(input bit t, input bit r, input bit rd, input logic [4:0] rn,
                      input logic [N_SLOTS-1:0] sf);
    @(negedge clk);
    frame_tick = t;
    run = r;
    spawn_ready = rd;
    rnd = rn;
    slot_free = sf;
  endtask

  function automatic logic [N_SLOTS-1:0] rand_free();
    int sel;
    sel = $urandom_range(0, 3);
    if (sel == 0) return '0;
    if (sel == 1) return N_SLOTS'(1) << $urandom_range(0, N_SLOTS - 1);
    return N_SLOTS'($urandom);
  endfunction

  // Drives frames until an offer is on the bus, with ready held low
  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 1'b1, 1'b0, 5'($urandom), {N_SLOTS{1'b1}});
      if (spawn_valid) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk("wait_valid_timeout", 0, 1);
  endtask

  bit ok;
  int held;

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    chk("rst0_valid", int'(spawn_valid), 0);
    chk("rst0_slot", int'(spawn_slot), 0);
    chk("rst0_lane", int'(spawn_lane), 0);
    chk("rst0_kind", int'(spawn_kind), 0);
    chk("rst0_gap", int'(gap_cur), GAP_INIT);
    chk("rst0_level", int'(level), 0);
    chk("rst0_count", int'(spawn_count), 0);
    chk("rst0_drop", int'(drop), 0);
    rstn = 1'b1;

    // Basic spawn: fixed slot and random word, tick every third cycle
    for (int i = 0; i < 60; i++)
      step((i % 3) == 2, 1'b1, 1'b1, 5'b10110, N_SLOTS'(8'b0000_0100));

    // Backpressure: ready low for 10 cycles while frames keep arriving
    wait_valid(ok);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b1, 1'b0, 5'($urandom), N_SLOTS'($urandom));
    for (int i = 0; i < 40; i++) step((i % 2) == 0, 1'b1, 1'b1, 5'($urandom), {N_SLOTS{1'b1}});

    // No free slot at the choice point
    for (int i = 0; i < 40; i++) step(1'b1, 1'b1, 1'b1, 5'($urandom), '0);

    // Long random game: reaches level saturation and gap clamp
    for (int i = 0; i < 3000; i++)
      step(1'($urandom_range(0, 1)), 1'b1, $urandom_range(0, 2) != 0, 5'($urandom), rand_free());
    chk("long_game_level_saturated", int'(level), 15);

    // Asynchronous reset while an offer is pending
    wait_valid(ok);
    #2 rstn = 1'b0;
    #1;
    chk("arst_valid", int'(spawn_valid), 0);
    chk("arst_slot", int'(spawn_slot), 0);
    chk("arst_lane", int'(spawn_lane), 0);
    chk("arst_kind", int'(spawn_kind), 0);
    chk("arst_gap", int'(gap_cur), GAP_INIT);
    chk("arst_level", int'(level), 0);
    chk("arst_count", int'(spawn_count), 0);
    chk("arst_drop", int'(drop), 0);
    @(negedge clk);
    rstn = 1'b1;

    // Build up a count, then abort an offer with ready high in the same cycle
    for (int i = 0; i < 200; i++) step(1'b1, 1'b1, 1'b1, 5'($urandom), {N_SLOTS{1'b1}});
    wait_valid(ok);
    held = accepted;
    run = 1'b0;
    spawn_ready = 1'b1;
    step(1'b1, 1'b0, 1'b1, 5'($urandom), {N_SLOTS{1'b1}});
    chk("abort_valid", int'(spawn_valid), 0);
    chk("abort_count_held", int'(spawn_count), held % 65536);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1, 5'($urandom), {N_SLOTS{1'b1}});
    step(1'b0, 1'b1, 1'b1, 5'($urandom), {N_SLOTS{1'b1}});
    step(1'b0, 1'b1, 1'b1, 5'($urandom), {N_SLOTS{1'b1}});
    chk("restart_count", int'(spawn_count), 0);
    chk("restart_level", int'(level), 0);
    chk("restart_gap", int'(gap_cur), GAP_INIT);

    // Random play with occasional pauses
    for (int i = 0; i < 2000; i++)
      step(1'($urandom_range(0, 1)), $urandom_range(0, 149) != 0,
           $urandom_range(0, 2) != 0, 5'($urandom), rand_free());

    step(1'b0, 1'b0, 1'b0, '0, '0);
    @(negedge clk);
    chk("queue_drained", evq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
